// File: rtl/seq_encoder_16to4.sv
// Serialises a request word into the binary indices of its set bits, lowest first.
// Optional ENC_COUNT_EN adds o_cnt, the number of indices still to be emitted.
//
// state  | meaning
// S_IDLE | ready for a word; zero words pulse o_none
// S_EMIT | presenting lowest pending index until consumed
module seq_encoder_16to4 #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [N-1:0] i_in,
    output logic [W-1:0] o_op,
    output logic         o_op_valid,
    input  logic         i_op_ready,
    output logic         o_last,
    output logic         o_none
`ifdef ENC_COUNT_EN
    ,
    output logic [W:0]   o_cnt
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pend;
    logic [N-1:0] w_pend_dec;

    function automatic logic [W-1:0] f_lsb_idx(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
        return idx;
    endfunction

    function automatic logic f_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    // Clearing the lowest set bit is exactly the bit currently on o_op.
    assign w_pend_dec = r_pend & (r_pend - N'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            o_in_ready <= 1'b1;
            o_op       <= '0;
            o_op_valid <= 1'b0;
            o_last     <= 1'b0;
            o_none     <= 1'b0;
        end else begin
            o_none <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        if (i_in != '0) begin
                            r_pend     <= i_in;
                            r_state    <= S_EMIT;
                            o_in_ready <= 1'b0;
                            o_op_valid <= 1'b1;
                            o_op       <= f_lsb_idx(i_in);
                            o_last     <= f_onehot(i_in);
                        end else begin
                            o_none <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (i_op_ready) begin
                        r_pend <= w_pend_dec;
                        if (o_last) begin
                            r_state    <= S_IDLE;
                            o_in_ready <= 1'b1;
                            o_op_valid <= 1'b0;
                            o_op       <= '0;
                            o_last     <= 1'b0;
                        end else begin
                            o_op   <= f_lsb_idx(w_pend_dec);
                            o_last <= f_onehot(w_pend_dec);
                        end
                    end
                end
            endcase
        end
    end

`ifdef ENC_COUNT_EN
    function automatic logic [W:0] f_popcount(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + (W+1)'(v[i]);
        end
        return c;
    endfunction

    assign o_cnt = f_popcount(r_pend);
`endif

endmodule

// File: tb/tb_seq_encoder_16to4.sv
// Directed and randomised bench for seq_encoder_16to4 against a queue-based model.
module tb_seq_encoder_16to4;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_w;
    logic [W-1:0] op;
    logic         op_valid;
    logic         op_ready;
    logic         last;
    logic         none;
`ifdef ENC_COUNT_EN
    logic [W:0]   cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    bit exp_none = 1'b0;

    seq_encoder_16to4 dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in       (in_w),
        .o_op       (op),
        .o_op_valid (op_valid),
        .i_op_ready (op_ready),
        .o_last     (last),
        .o_none     (none)
`ifdef ENC_COUNT_EN
        ,
        .o_cnt      (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the queue holds the indices still to be emitted; empty means idle.
    task automatic model_step();
        if (rst) begin
            exp_q.delete();
            exp_none = 1'b0;
        end else if (exp_q.size() == 0) begin
            exp_none = 1'b0;
            if (in_valid) begin
                if (in_w == '0) exp_none = 1'b1;
                else for (int i = 0; i < N; i++) if (in_w[i]) exp_q.push_back(i);
            end
        end else begin
            exp_none = 1'b0;
            if (op_ready) void'(exp_q.pop_front());
        end
    endtask

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
        chk("op_valid", 32'(op_valid), 32'(exp_q.size() != 0));
        chk("op",       32'(op),       (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
        chk("last",     32'(last),     32'(exp_q.size() == 1));
        chk("none",     32'(none),     32'(exp_none));
`ifdef ENC_COUNT_EN
        chk("cnt",      32'(cnt),      32'(exp_q.size()));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    logic [N-1:0] rnd;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_w = '0; op_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        rst = 1'b0;

        // single-bit word
        in_w = 16'h0001; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk("w1_op", 32'(op), 32'd0);
        chk("w1_last", 32'(last), 32'd1);
        tick();
        chk("w1_idle", 32'(in_ready), 32'd1);

        // 8421 streamed back to back
        in_w = 16'h8421; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk("s_op0", 32'(op), 32'd0);  chk("s_last0", 32'(last), 32'd0); tick();
        chk("s_op1", 32'(op), 32'd5);  tick();
        chk("s_op2", 32'(op), 32'd10); tick();
        chk("s_op3", 32'(op), 32'd15); chk("s_last3", 32'(last), 32'd1); tick();
        chk("s_idle", 32'(in_ready), 32'd1);

        // all-zero word
        in_w = 16'h0000; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        chk("z_none", 32'(none), 32'd1);
        chk("z_opv", 32'(op_valid), 32'd0);
        tick();
        chk("z_none_off", 32'(none), 32'd0);
        chk("z_ready", 32'(in_ready), 32'd1);

        // stall with op_ready low
        in_w = 16'h0006; in_valid = 1'b1; tick();
        in_valid = 1'b0; op_ready = 1'b0;
        tick(); tick(); tick();
        chk("st_op", 32'(op), 32'd1);
        chk("st_last", 32'(last), 32'd0);
        op_ready = 1'b1; tick();
        chk("st_op2", 32'(op), 32'd2);
        chk("st_last2", 32'(last), 32'd1);
        tick();

        // reset mid-emit
        in_w = 16'hFFFF; in_valid = 1'b1; tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("rm_op", 32'(op), 32'd3);
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("rm_opv", 32'(op_valid), 32'd0);
        chk("rm_op0", 32'(op), 32'd0);
        chk("rm_ready", 32'(in_ready), 32'd1);
        tick();
        chk("rm_quiet", 32'(op_valid), 32'd0);

        // words offered during EMIT are ignored
        in_w = 16'h8421; in_valid = 1'b1; tick();
        in_w = 16'h0002;
        chk("ig_op0", 32'(op), 32'd0);
`ifdef ENC_COUNT_EN
        chk("ig_cnt0", 32'(cnt), 32'd4);
`endif
        tick();
        chk("ig_op1", 32'(op), 32'd5);
`ifdef ENC_COUNT_EN
        chk("ig_cnt1", 32'(cnt), 32'd3);
`endif
        tick();
        chk("ig_op2", 32'(op), 32'd10);
        tick();
        chk("ig_op3", 32'(op), 32'd15);
`ifdef ENC_COUNT_EN
        chk("ig_cnt3", 32'(cnt), 32'd1);
`endif
        in_valid = 1'b0;
        tick();
        chk("ig_idle", 32'(in_ready), 32'd1);
`ifdef ENC_COUNT_EN
        chk("ig_cnt_end", 32'(cnt), 32'd0);
`endif

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            rnd = N'($urandom);
            case ($urandom_range(0, 3))
                0: in_w = '0;
                1: in_w = N'(1) << $urandom_range(0, N - 1);
                2: in_w = rnd;
                default: in_w = rnd & N'($urandom);
            endcase
            in_valid = ($urandom_range(0, 2) != 0);
            op_ready = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
